// File: rtl/bit_unit_pkg.sv
// Shared encodings for the bit unit: instruction ops, operand sources and
// the A/B/LU mux selects seen by both the sequencer and the bit unit decoders.
package bit_unit_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_LD    = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NAND  = 4'd5,
    OP_LDOV  = 4'd6,
    OP_LDCMP = 4'd7,
    OP_LDSEM = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    SRC_IMM = 2'd0,
    SRC_RAM = 2'd1,
    SRC_REG = 2'd2,
    SRC_RSV = 2'd3
  } src_e;

  typedef enum logic [2:0] {
    A_ARG = 3'd0,
    A_RAM = 3'd1,
    A_REG = 3'd2,
    A_LU  = 3'd3,
    A_OV  = 3'd4,
    A_CMP = 3'd5,
    A_SEM = 3'd6
  } a_op_e;

  typedef enum logic [1:0] {
    B_ARG = 2'd0,
    B_RAM = 2'd1,
    B_REG = 2'd2
  } b_op_e;

  typedef enum logic [1:0] {
    LU_AND  = 2'd0,
    LU_OR   = 2'd1,
    LU_XOR  = 2'd2,
    LU_NAND = 2'd3
  } lu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAM_WAIT,
    S_SEM_WAIT,
    S_EXEC
  } seq_state_e;

  typedef struct packed {
    a_op_e  a_op;
    b_op_e  b_op;
    lu_op_e lu_op;
    logic   needs_ram;
    logic   needs_sem;
    logic   illegal;
  } dec_t;

  // Ops LD..NAND are the only ones that take an operand from SEQ_InstrSrc.
  function automatic logic uses_src(input logic [3:0] op);
    return (op >= 4'(OP_LD)) && (op <= 4'(OP_NAND));
  endfunction

endpackage

// File: rtl/bit_op_decoder.sv
// Combinational decode of {op, src} into bit unit mux selects and the
// sequencing needs (RAM fetch, semaphore acquire) of one instruction.
module bit_op_decoder
  import bit_unit_pkg::*;
(
  input  logic [3:0] op,
  input  logic [1:0] src,
  output dec_t       dec
);

  b_op_e b_sel;
  a_op_e a_sel;

  always_comb begin
    case (src)
      SRC_RAM: begin b_sel = B_RAM; a_sel = A_RAM; end
      SRC_REG: begin b_sel = B_REG; a_sel = A_REG; end
      default: begin b_sel = B_ARG; a_sel = A_ARG; end
    endcase
  end

  always_comb begin
    dec = '0;
    case (op)
      OP_NOP:   ;
      OP_LD:    dec.a_op = a_sel;
      OP_AND:   begin dec.a_op = A_LU; dec.b_op = b_sel; dec.lu_op = LU_AND;  end
      OP_OR:    begin dec.a_op = A_LU; dec.b_op = b_sel; dec.lu_op = LU_OR;   end
      OP_XOR:   begin dec.a_op = A_LU; dec.b_op = b_sel; dec.lu_op = LU_XOR;  end
      OP_NAND:  begin dec.a_op = A_LU; dec.b_op = b_sel; dec.lu_op = LU_NAND; end
      OP_LDOV:  dec.a_op = A_OV;
      OP_LDCMP: dec.a_op = A_CMP;
      OP_LDSEM: begin dec.a_op = A_SEM; dec.needs_sem = 1'b1; end
      default:  dec.illegal = 1'b1;
    endcase
    if (uses_src(op)) begin
      if (src == SRC_RSV) dec.illegal   = 1'b1;
      if (src == SRC_RAM) dec.needs_ram = 1'b1;
    end
  end

endmodule

// File: rtl/bit_unit_sequencer.sv
// Sequences one bit instruction at a time: optional RAM/semaphore wait with
// timeout, then a single A write strobe carrying the decoded mux selects.
module bit_unit_sequencer
  import bit_unit_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int ADDR_W  = 10
) (
  input  logic              CLK,
  input  logic              CPU_Reset,
  input  logic              SEQ_InstrValid,
  output logic              SEQ_InstrReady,
  input  logic [3:0]        SEQ_InstrOp,
  input  logic [1:0]        SEQ_InstrSrc,
  input  logic [ADDR_W-1:0] SEQ_InstrAddr,
  output logic              SEQ_RAMReq,
  output logic [ADDR_W-1:0] SEQ_RAMAddr,
  input  logic              SEQ_RAMAck,
  output logic              SEQ_SemReq,
  input  logic              SEQ_SemGrant,
  output logic              BITUNIT_A_WE,
  output logic [2:0]        BITUNIT_A_OPCode,
  output logic [1:0]        BITUNIT_B_OPCode,
  output logic [1:0]        BITUNIT_LU_OPCode,
  output logic              SEQ_Busy,
  output logic              SEQ_Fault
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Counter value during the final wait cycle; ack/grant there still wins.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fault_q, fault_d;
  logic              rdy_q;
  dec_t              in_dec, dec_q;
  logic [ADDR_W-1:0] addr_q;
  logic              accept;

  bit_op_decoder u_dec (
    .op  (SEQ_InstrOp),
    .src (SEQ_InstrSrc),
    .dec (in_dec)
  );

  assign accept = SEQ_InstrValid & SEQ_InstrReady;

  always_ff @(posedge CLK or posedge CPU_Reset) begin
    if (CPU_Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      rdy_q   <= 1'b0;
      dec_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      rdy_q   <= 1'b1;
      if (accept) begin
        dec_q  <= in_dec;
        addr_q <= SEQ_InstrAddr;
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    fault_d           = 1'b0;
    SEQ_RAMReq        = 1'b0;
    SEQ_SemReq        = 1'b0;
    BITUNIT_A_WE      = 1'b0;
    BITUNIT_A_OPCode  = '0;
    BITUNIT_B_OPCode  = '0;
    BITUNIT_LU_OPCode = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_dec.illegal) begin
            fault_d = 1'b1;
          end else if (SEQ_InstrOp == 4'(OP_NOP)) begin
            state_d = S_IDLE;
          end else if (in_dec.needs_ram) begin
            state_d = S_RAM_WAIT;
            cnt_d   = '0;
          end else if (in_dec.needs_sem) begin
            state_d = S_SEM_WAIT;
            cnt_d   = '0;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_RAM_WAIT: begin
        SEQ_RAMReq = 1'b1;
        if (SEQ_RAMAck) begin
          state_d = S_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SEM_WAIT: begin
        SEQ_SemReq = 1'b1;
        if (SEQ_SemGrant) begin
          state_d = S_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_EXEC: begin
        BITUNIT_A_WE      = 1'b1;
        BITUNIT_A_OPCode  = dec_q.a_op;
        BITUNIT_B_OPCode  = dec_q.b_op;
        BITUNIT_LU_OPCode = dec_q.lu_op;
        state_d           = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign SEQ_InstrReady = rdy_q && (state_q == S_IDLE);
  assign SEQ_Busy       = (state_q != S_IDLE);
  assign SEQ_Fault      = fault_q;
  assign SEQ_RAMAddr    = SEQ_RAMReq ? addr_q : '0;

endmodule

// File: tb/tb_bit_unit_sequencer.sv
// Directed bench: table of single-instruction vectors plus hand-written
// sequences for RAM wait, semaphore timeout, boundary ack and mid-op reset.
module tb_bit_unit_sequencer;

  localparam int TIMEOUT = 15;
  localparam int ADDR_W  = 10;

  logic              CLK = 1'b0;
  logic              CPU_Reset = 1'b1;
  logic              valid = 1'b0;
  logic [3:0]        op = '0;
  logic [1:0]        src = '0;
  logic [ADDR_W-1:0] addr = '0;
  logic              ack = 1'b0;
  logic              grant = 1'b0;
  logic              ready, ram_req, sem_req, a_we, busy, fault;
  logic [ADDR_W-1:0] ram_addr;
  logic [2:0]        a_opc;
  logic [1:0]        b_opc, lu_opc;

  int n_cmp = 0;
  int n_err = 0;

  bit_unit_sequencer #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
    .CLK               (CLK),
    .CPU_Reset         (CPU_Reset),
    .SEQ_InstrValid    (valid),
    .SEQ_InstrReady    (ready),
    .SEQ_InstrOp       (op),
    .SEQ_InstrSrc      (src),
    .SEQ_InstrAddr     (addr),
    .SEQ_RAMReq        (ram_req),
    .SEQ_RAMAddr       (ram_addr),
    .SEQ_RAMAck        (ack),
    .SEQ_SemReq        (sem_req),
    .SEQ_SemGrant      (grant),
    .BITUNIT_A_WE      (a_we),
    .BITUNIT_A_OPCode  (a_opc),
    .BITUNIT_B_OPCode  (b_opc),
    .BITUNIT_LU_OPCode (lu_opc),
    .SEQ_Busy          (busy),
    .SEQ_Fault         (fault)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] op;
    logic [1:0] src;
    logic       we;
    logic [2:0] a;
    logic [1:0] b;
    logic [1:0] lu;
    logic       fault;
    logic       rdy;
  } vec_t;

  vec_t tbl[13];

  // {we, A, B, LU, fault, ram_req, sem_req, ready, busy}
  function automatic logic [12:0] pk(input logic we, input logic [2:0] a,
                                     input logic [1:0] b, input logic [1:0] lu,
                                     input logic f, input logic rq, input logic sq,
                                     input logic rdy, input logic bsy);
    return {we, a, b, lu, f, rq, sq, rdy, bsy};
  endfunction

  function automatic logic [12:0] obs();
    return pk(a_we, a_opc, b_opc, lu_opc, fault, ram_req, sem_req, ready, busy);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [1:0] s, input logic [ADDR_W-1:0] a);
    op = o; src = s; addr = a; valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  logic [12:0] IDLE_OBS;

  initial begin
    IDLE_OBS = pk(0, 0, 0, 0, 0, 0, 0, 1, 0);
    //        op     src    we a  b  lu f  rdy
    tbl[0]  = '{4'd1,  2'd0, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{4'd1,  2'd2, 1, 2, 0, 0, 0, 0};
    tbl[2]  = '{4'd2,  2'd2, 1, 3, 2, 0, 0, 0};
    tbl[3]  = '{4'd3,  2'd0, 1, 3, 0, 1, 0, 0};
    tbl[4]  = '{4'd4,  2'd2, 1, 3, 2, 2, 0, 0};
    tbl[5]  = '{4'd5,  2'd0, 1, 3, 0, 3, 0, 0};
    tbl[6]  = '{4'd6,  2'd3, 1, 4, 0, 0, 0, 0};
    tbl[7]  = '{4'd7,  2'd1, 1, 5, 0, 0, 0, 0};
    tbl[8]  = '{4'd0,  2'd0, 0, 0, 0, 0, 0, 1};
    tbl[9]  = '{4'd12, 2'd0, 0, 0, 0, 0, 1, 1};
    tbl[10] = '{4'd4,  2'd3, 0, 0, 0, 0, 1, 1};
    tbl[11] = '{4'd15, 2'd2, 0, 0, 0, 0, 1, 1};
    tbl[12] = '{4'd1,  2'd3, 0, 0, 0, 0, 1, 1};

    // Reset behaviour
    #3;
    check("in_reset", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    tick(); tick();
    CPU_Reset = 1'b0;
    check("just_released", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    tick();
    check("ready_after_release", 32'(obs()), 32'(IDLE_OBS));

    // Table of single instructions
    for (int i = 0; i < 13; i++) begin
      issue(tbl[i].op, tbl[i].src, 10'h3C3);
      check($sformatf("vec%0d", i), 32'(obs()),
            32'(pk(tbl[i].we, tbl[i].a, tbl[i].b, tbl[i].lu, tbl[i].fault,
                   0, 0, tbl[i].rdy, tbl[i].we)));
      tick();
      check($sformatf("vec%0d_idle", i), 32'(obs()), 32'(IDLE_OBS));
    end

    // LD imm followed immediately by AND reg
    op = 4'd1; src = 2'd0; valid = 1'b1;
    tick();
    check("b2b_ld", 32'(obs()), 32'(pk(1, 0, 0, 0, 0, 0, 0, 0, 1)));
    op = 4'd2; src = 2'd2;
    tick();
    check("b2b_gap", 32'(obs()), 32'(IDLE_OBS));
    tick();
    valid = 1'b0;
    check("b2b_and", 32'(obs()), 32'(pk(1, 3, 2, 0, 0, 0, 0, 0, 1)));
    tick();

    // OR from RAM, ack in third request cycle
    issue(4'd3, 2'd1, 10'h155);
    check("ram_addr", 32'(ram_addr), 32'h155);
    check("ram_c1", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 1, 0, 0, 1)));
    tick();
    check("ram_c2", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 1, 0, 0, 1)));
    tick();
    check("ram_c3", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 1, 0, 0, 1)));
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ram_exec", 32'(obs()), 32'(pk(1, 3, 1, 1, 0, 0, 0, 0, 1)));
    tick();
    check("ram_idle", 32'(obs()), 32'(IDLE_OBS));

    // LDSEM with no grant: timeout
    begin
      int  cyc;
      logic we_seen;
      cyc = 0; we_seen = 1'b0;
      issue(4'd8, 2'd0, '0);
      while (sem_req && cyc < 40) begin
        cyc++;
        if (a_we) we_seen = 1'b1;
        tick();
      end
      check("sem_req_cycles", 32'(cyc), 32'(TIMEOUT));
      check("sem_no_we", 32'(we_seen), 32'd0);
      check("sem_fault", 32'(obs()), 32'(pk(0, 0, 0, 0, 1, 0, 0, 1, 0)));
      tick();
      check("sem_fault_clear", 32'(obs()), 32'(IDLE_OBS));
    end

    // Late grant and stray ack while idle are ignored
    grant = 1'b1; ack = 1'b1;
    tick();
    grant = 1'b0; ack = 1'b0;
    check("stray_ignored", 32'(obs()), 32'(IDLE_OBS));

    // Ack in the last allowed wait cycle still executes
    issue(4'd1, 2'd1, 10'h3FF);
    for (int i = 1; i < TIMEOUT; i++) begin
      if (!ram_req) check($sformatf("edge_req_c%0d", i), 32'(ram_req), 32'd1);
      tick();
    end
    check("edge_req_last", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 1, 0, 0, 1)));
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("edge_exec", 32'(obs()), 32'(pk(1, 1, 0, 0, 0, 0, 0, 0, 1)));
    tick();
    check("edge_idle", 32'(obs()), 32'(IDLE_OBS));

    // Reset in RAM_WAIT drops the request at once
    issue(4'd1, 2'd1, 10'h02A);
    check("rst_req_before", 32'(ram_req), 32'd1);
    #2 CPU_Reset = 1'b1;
    #1;
    check("rst_async_drop", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    tick();
    CPU_Reset = 1'b0;
    tick();
    check("rst_ready", 32'(obs()), 32'(IDLE_OBS));
    issue(4'd1, 2'd0, '0);
    check("rst_then_ld", 32'(obs()), 32'(pk(1, 0, 0, 0, 0, 0, 0, 0, 1)));
    tick();
    check("rst_then_idle", 32'(obs()), 32'(IDLE_OBS));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
